// File: rtl/silife_max7219_pkg.sv
// MAX7219 register map and 16-bit serial word layout, shared by the SPI driver and the
// receive-side chain model.
package silife_max7219_pkg;

    localparam int unsigned WordBits = 16;
    localparam int unsigned NumRows  = 8;

    typedef enum logic [3:0] {
        RegNoop      = 4'h0,
        RegDigit0    = 4'h1,
        RegDigit1    = 4'h2,
        RegDigit2    = 4'h3,
        RegDigit3    = 4'h4,
        RegDigit4    = 4'h5,
        RegDigit5    = 4'h6,
        RegDigit6    = 4'h7,
        RegDigit7    = 4'h8,
        RegDecode    = 4'h9,
        RegIntensity = 4'hA,
        RegScanLimit = 4'hB,
        RegShutdown  = 4'hC,
        RegTest      = 4'hF
    } reg_addr_e;

    // Lower 12 bits of a word; the top nibble is don't-care on the real part.
    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic [3:0] hdr;
        cmd_t       cmd;
    } word_t;

    function automatic word_t make_word(input reg_addr_e addr, input logic [7:0] data);
        word_t w;
        w.hdr      = 4'h0;
        w.cmd.addr = addr;
        w.cmd.data = data;
        return w;
    endfunction

    // Digit register 1..8 selects row 0..7.
    function automatic logic [2:0] row_index(input logic [3:0] addr);
        return 3'(addr - 4'd1);
    endfunction

endpackage

// File: rtl/silife_spi_slave.sv
// SPI receive front end: input synchronizers, edge detect, shift register, bit counter and a
// latch strobe on the chip-select rising edge.
module silife_spi_slave
    import silife_max7219_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 16,
    localparam int unsigned SrBits  = WordBits * NUM_WORDS,
    localparam int unsigned CntBits = $clog2(SrBits) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_cs,
    input  logic                     i_sck,
    input  logic                     i_mosi,
    output cmd_t [NUM_WORDS-1:0]     o_cmd,
    output logic                     o_dout,
    output logic                     o_latch,
    output logic [CntBits-1:0]       o_count
);

    localparam logic [CntBits-1:0] CntMax = '1;

    logic [1:0]        cs_sync_q, sck_sync_q, mosi_sync_q;
    logic              cs_prev_q, sck_prev_q;
    logic [SrBits-1:0] sr_q, sr_d;
    logic [CntBits-1:0] cnt_q, cnt_d;
    logic              cs_s, sck_s, mosi_s;
    logic              sck_rise, cs_rise, cs_fall, shift_en;

    assign cs_s   = cs_sync_q[1];
    assign sck_s  = sck_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    // A clock edge coinciding with the CS rise sees cs_s high and is dropped.
    assign shift_en = sck_rise & ~cs_s;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (cs_fall) begin
            cnt_d = '0;
        end
        if (shift_en) begin
            sr_d = {sr_q[SrBits-2:0], mosi_s};
            if (cnt_d != CntMax) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
            sr_q        <= '0;
            cnt_q       <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], i_cs};
            sck_sync_q  <= {sck_sync_q[0], i_sck};
            mosi_sync_q <= {mosi_sync_q[0], i_mosi};
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        o_cmd = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            o_cmd[k] = cmd_t'(sr_q[WordBits*k +: 12]);
        end
    end

    assign o_dout  = sr_q[SrBits-1];
    assign o_latch = cs_rise & (cnt_q != '0);
    assign o_count = cnt_q;

endmodule

// File: rtl/silife_max7219_model.sv
// Receive-side model of a daisy-chained MAX7219 string: decodes one word per device on each
// LOAD rising edge into per-device register files and exposes them through a registered read port.
module silife_max7219_model
    import silife_max7219_pkg::*;
#(
    parameter int unsigned NUM_DEVICES = 16,
    localparam int unsigned DevBits = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1,
    localparam int unsigned CntBits = $clog2(WordBits * NUM_DEVICES) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_cs,
    input  logic               i_sck,
    input  logic               i_mosi,
    output logic               o_dout,
    input  logic [DevBits-1:0] i_rd_dev,
    input  logic [2:0]         i_rd_row,
    output logic [7:0]         o_rd_row_data,
    output logic [3:0]         o_rd_intensity,
    output logic [2:0]         o_rd_scan_limit,
    output logic [7:0]         o_rd_decode,
    output logic               o_rd_shutdown_n,
    output logic               o_rd_test,
    output logic               o_update,
    output logic               o_length_error
);

    localparam logic [CntBits-1:0] FullCount = CntBits'(WordBits * NUM_DEVICES);

    cmd_t [NUM_DEVICES-1:0] cmd;
    logic                   latch;
    logic [CntBits-1:0]     count;

    logic [7:0] rows_q       [NUM_DEVICES][NumRows];
    logic [7:0] decode_q     [NUM_DEVICES];
    logic [3:0] intensity_q  [NUM_DEVICES];
    logic [2:0] scan_limit_q [NUM_DEVICES];
    logic       shutdown_n_q [NUM_DEVICES];
    logic       test_q       [NUM_DEVICES];
    logic       update_q, length_error_q;

    logic [7:0] rd_row_q, rd_decode_q;
    logic [3:0] rd_intensity_q;
    logic [2:0] rd_scan_limit_q;
    logic       rd_shutdown_n_q, rd_test_q;

    silife_spi_slave #(
        .NUM_WORDS (NUM_DEVICES)
    ) u_spi_slave (
        .clk     (clk),
        .reset   (reset),
        .i_cs    (i_cs),
        .i_sck   (i_sck),
        .i_mosi  (i_mosi),
        .o_cmd   (cmd),
        .o_dout  (o_dout),
        .o_latch (latch),
        .o_count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_DEVICES; k++) begin
                for (int r = 0; r < NumRows; r++) begin
                    rows_q[k][r] <= '0;
                end
                decode_q[k]     <= '0;
                intensity_q[k]  <= '0;
                scan_limit_q[k] <= '0;
                shutdown_n_q[k] <= 1'b0;
                test_q[k]       <= 1'b0;
            end
            update_q       <= 1'b0;
            length_error_q <= 1'b0;
        end else begin
            update_q <= latch;
            if (latch) begin
                if (count != FullCount) begin
                    length_error_q <= 1'b1;
                end
                // Every device decodes its own word in the same cycle.
                for (int k = 0; k < NUM_DEVICES; k++) begin
                    case (cmd[k].addr)
                        RegDigit0, RegDigit1, RegDigit2, RegDigit3,
                        RegDigit4, RegDigit5, RegDigit6, RegDigit7: begin
                            rows_q[k][row_index(cmd[k].addr)] <= cmd[k].data;
                        end
                        RegDecode:    decode_q[k]     <= cmd[k].data;
                        RegIntensity: intensity_q[k]  <= cmd[k].data[3:0];
                        RegScanLimit: scan_limit_q[k] <= cmd[k].data[2:0];
                        RegShutdown:  shutdown_n_q[k] <= cmd[k].data[0];
                        RegTest:      test_q[k]       <= cmd[k].data[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Registered read: a read coinciding with a latch returns the pre-latch contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_row_q        <= '0;
            rd_decode_q     <= '0;
            rd_intensity_q  <= '0;
            rd_scan_limit_q <= '0;
            rd_shutdown_n_q <= 1'b0;
            rd_test_q       <= 1'b0;
        end else begin
            rd_row_q        <= rows_q[i_rd_dev][i_rd_row];
            rd_decode_q     <= decode_q[i_rd_dev];
            rd_intensity_q  <= intensity_q[i_rd_dev];
            rd_scan_limit_q <= scan_limit_q[i_rd_dev];
            rd_shutdown_n_q <= shutdown_n_q[i_rd_dev];
            rd_test_q       <= test_q[i_rd_dev];
        end
    end

    assign o_rd_row_data   = rd_row_q;
    assign o_rd_decode     = rd_decode_q;
    assign o_rd_intensity  = rd_intensity_q;
    assign o_rd_scan_limit = rd_scan_limit_q;
    assign o_rd_shutdown_n = rd_shutdown_n_q;
    assign o_rd_test       = rd_test_q;
    assign o_update        = update_q;
    assign o_length_error  = length_error_q;

endmodule

// File: tb/tb_silife_max7219_model.sv
// Directed bench for the MAX7219 chain model: drives SPI frames and checks the decoded state.
module tb_silife_max7219_model;
    import silife_max7219_pkg::*;

    localparam int unsigned NDEV = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_cs = 1'b1;
    logic       i_sck = 1'b0;
    logic       i_mosi = 1'b0;
    logic [3:0] i_rd_dev = '0;
    logic [2:0] i_rd_row = '0;
    logic       o_dout, o_rd_shutdown_n, o_rd_test, o_update, o_length_error;
    logic [7:0] o_rd_row_data, o_rd_decode;
    logic [3:0] o_rd_intensity;
    logic [2:0] o_rd_scan_limit;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    int upd_cnt = 0;
    int snap = 0;
    logic [15:0] frame [NDEV];
    logic [15:0] init_w [4];

    silife_max7219_model #(
        .NUM_DEVICES (NDEV)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_cs            (i_cs),
        .i_sck           (i_sck),
        .i_mosi          (i_mosi),
        .o_dout          (o_dout),
        .i_rd_dev        (i_rd_dev),
        .i_rd_row        (i_rd_row),
        .o_rd_row_data   (o_rd_row_data),
        .o_rd_intensity  (o_rd_intensity),
        .o_rd_scan_limit (o_rd_scan_limit),
        .o_rd_decode     (o_rd_decode),
        .o_rd_shutdown_n (o_rd_shutdown_n),
        .o_rd_test       (o_rd_test),
        .o_update        (o_update),
        .o_length_error  (o_length_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_update === 1'b1) upd_cnt <= upd_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int dev, input int row);
        i_rd_dev = 4'(dev);
        i_rd_row = 3'(row);
        tick(1);
    endtask

    task automatic send_bit(input logic b);
        i_mosi = b;
        i_sck  = 1'b0;
        tick(3);
        i_sck  = 1'b1;
        tick(3);
    endtask

    // Sends frame[nwords-1] first so that frame[k] ends up in device k.
    task automatic send_frame(input int nwords);
        i_cs = 1'b0;
        tick(4);
        for (int k = nwords - 1; k >= 0; k--) begin
            for (int b = 15; b >= 0; b--) send_bit(frame[k][b]);
        end
        i_sck = 1'b0;
        tick(4);
        i_cs = 1'b1;
        tick(8);
    endtask

    initial begin
        init_w[0] = 16'h0F00;
        init_w[1] = 16'h0B07;
        init_w[2] = 16'h0900;
        init_w[3] = 16'h0A05;

        // Reset state
        tick(3);
        reset = 1'b0;
        tick(6);
        rd(0, 0);
        check("rst_row", 32'(o_rd_row_data), 0);
        check("rst_int", 32'(o_rd_intensity), 0);
        check("rst_scan", 32'(o_rd_scan_limit), 0);
        check("rst_dec", 32'(o_rd_decode), 0);
        check("rst_shdn", 32'(o_rd_shutdown_n), 0);
        check("rst_test", 32'(o_rd_test), 0);
        check("rst_upd", 32'(o_update), 0);
        check("rst_lerr", 32'(o_length_error), 0);
        check("rst_dout", 32'(o_dout), 0);
        check("rst_updcnt", 32'(upd_cnt), 0);

        // Init sequence
        snap = upd_cnt;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NDEV; k++) frame[k] = init_w[f];
            send_frame(NDEV);
        end
        check("init_upd", 32'(upd_cnt - snap), 4);
        check("init_lerr", 32'(o_length_error), 0);
        for (int k = 0; k < NDEV; k++) begin
            rd(k, 0);
            check("init_test", 32'(o_rd_test), 0);
            check("init_scan", 32'(o_rd_scan_limit), 7);
            check("init_dec", 32'(o_rd_decode), 0);
            check("init_int", 32'(o_rd_intensity), 5);
            check("init_shdn", 32'(o_rd_shutdown_n), 0);
        end

        // Row write: device k writes value k into row k&7
        snap = upd_cnt;
        for (int k = 0; k < NDEV; k++) frame[k] = {4'h0, 4'((k & 7) + 1), 8'(k)};
        send_frame(NDEV);
        check("row_upd", 32'(upd_cnt - snap), 1);
        for (int k = 0; k < NDEV; k++) begin
            for (int r = 0; r < 8; r++) begin
                rd(k, r);
                check("row_data", 32'(o_rd_row_data), (r == (k & 7)) ? 32'(k) : 32'd0);
            end
        end

        // Short frame: devices 0-4 get intensity j+8, devices 5-15 see the old words moved up by 5
        snap = upd_cnt;
        for (int j = 0; j < 5; j++) frame[j] = {8'h0A, 8'(j + 8)};
        send_frame(5);
        check("short_upd", 32'(upd_cnt - snap), 1);
        check("short_lerr", 32'(o_length_error), 1);
        for (int j = 0; j < 5; j++) begin
            rd(j, j);
            check("short_int", 32'(o_rd_intensity), 32'(j + 8));
            check("short_row_keep", 32'(o_rd_row_data), 32'(j));
        end
        for (int k = 5; k < NDEV; k++) begin
            rd(k, (k - 5) & 7);
            check("short_int_keep", 32'(o_rd_intensity), 5);
            check("short_row_shift", 32'(o_rd_row_data), 32'(k - 5));
            rd(k, k & 7);
            check("short_row_old", 32'(o_rd_row_data), 32'(k));
        end

        // Gated edges: sck while cs high, then a cs pulse with no sck
        snap = upd_cnt;
        for (int i = 0; i < 20; i++) begin
            i_mosi = 1'b1;
            i_sck  = ~i_sck;
            tick(3);
        end
        i_sck = 1'b0;
        tick(4);
        i_cs = 1'b0;
        tick(6);
        i_cs = 1'b1;
        tick(8);
        check("gate_upd", 32'(upd_cnt - snap), 0);
        check("gate_lerr", 32'(o_length_error), 1);
        rd(0, 0);
        check("gate_int", 32'(o_rd_intensity), 8);
        rd(6, 1);
        check("gate_row", 32'(o_rd_row_data), 1);

        // Shutdown off everywhere; device 15 word carries a set header bit, sent first
        snap = upd_cnt;
        for (int k = 0; k < NDEV; k++) frame[k] = 16'h0C01;
        frame[NDEV-1] = 16'h8C01;
        send_frame(NDEV);
        check("shdn_upd", 32'(upd_cnt - snap), 1);
        check("shdn_dout", 32'(o_dout), 1);
        check("shdn_lerr_sticky", 32'(o_length_error), 1);
        for (int k = 0; k < NDEV; k++) begin
            rd(k, 0);
            check("shdn_on", 32'(o_rd_shutdown_n), 1);
        end

        // Reset in the middle of a frame
        i_cs = 1'b0;
        tick(4);
        for (int i = 0; i < 100; i++) send_bit(1'b1);
        i_sck = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        rd(0, 0);
        check("mrst_int", 32'(o_rd_intensity), 0);
        check("mrst_scan", 32'(o_rd_scan_limit), 0);
        check("mrst_shdn", 32'(o_rd_shutdown_n), 0);
        check("mrst_lerr", 32'(o_length_error), 0);
        check("mrst_dout", 32'(o_dout), 0);
        rd(6, 1);
        check("mrst_row", 32'(o_rd_row_data), 0);
        snap = upd_cnt;
        i_cs = 1'b1;
        tick(8);
        check("mrst_nolatch", 32'(upd_cnt - snap), 0);

        // Full frame after reset decodes normally
        snap = upd_cnt;
        for (int k = 0; k < NDEV; k++) frame[k] = {8'h0B, 8'(k & 7)};
        send_frame(NDEV);
        check("post_upd", 32'(upd_cnt - snap), 1);
        check("post_lerr", 32'(o_length_error), 0);
        for (int k = 0; k < NDEV; k++) begin
            rd(k, 0);
            check("post_scan", 32'(o_rd_scan_limit), 32'(k & 7));
            check("post_shdn", 32'(o_rd_shutdown_n), 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
